// File: rtl/div_responder_pkg.sv
// div_responder_pkg: shared divider constants, state encoding
package div_responder_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int CNT_WIDTH = 6;
   localparam int DIV_ITERS = 32;
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_t;
endpackage

// File: rtl/div_responder_if.sv
// div_responder_if: start/done handshake between control unit and divider
interface div_responder_if #(
   parameter int DATA_WIDTH = 32
);
   logic start;
   logic [DATA_WIDTH-1:0] dividend;
   logic [DATA_WIDTH-1:0] divisor;
   logic busy;
   logic done;
   logic div_zero;
   logic [DATA_WIDTH-1:0] quotient;
   logic [DATA_WIDTH-1:0] remainder;
   modport master (
      output start, dividend, divisor,
      input  busy, done, div_zero, quotient, remainder
   );
   modport slave (
      input  start, dividend, divisor,
      output busy, done, div_zero, quotient, remainder
   );
endinterface

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration on magnitudes
module div_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rem,
   input  logic                  next_bit,
   input  logic [DATA_WIDTH-1:0] dvs,
   output logic [DATA_WIDTH-1:0] rem_next,
   output logic                  q_bit
);
   logic [DATA_WIDTH:0] shifted;
   logic [DATA_WIDTH:0] trial;
   // rem < dvs <= 2^(W-1), so shifted never exceeds W bits and the trial sign bit is exact
   always_comb begin
      shifted = {rem, next_bit};
      trial = shifted - {1'b0, dvs};
      q_bit = ~trial[DATA_WIDTH];
      rem_next = q_bit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
   end
endmodule

// File: rtl/div_responder.sv
// div_responder: multicycle signed divider answering control-unit DIV requests
module div_responder #(
   parameter int DATA_WIDTH = div_responder_pkg::DATA_WIDTH,
   parameter int CNT_WIDTH = div_responder_pkg::CNT_WIDTH
) (
   input logic clk,
   input logic reset,
   div_responder_if.slave bus
);
   import div_responder_pkg::*;
   div_state_t state;
   logic [CNT_WIDTH-1:0] counter;
   logic [DATA_WIDTH-1:0] rem_p;
   logic [DATA_WIDTH-1:0] dvd_m;
   logic [DATA_WIDTH-1:0] dvs_m;
   logic [DATA_WIDTH-1:0] rem_n;
   logic [DATA_WIDTH-1:0] quotient;
   logic [DATA_WIDTH-1:0] remainder;
   logic q_bit;
   logic q_sign;
   logic r_sign;
   logic div_zero;
   logic dvd_neg;
   logic dvs_neg;

   assign dvd_neg = bus.dividend[DATA_WIDTH-1];
   assign dvs_neg = bus.divisor[DATA_WIDTH-1];
   assign bus.busy = (state == DIV_CALC) || (state == DIV_FIX);
   assign bus.done = state == DIV_DONE;
   assign bus.div_zero = div_zero;
   assign bus.quotient = quotient;
   assign bus.remainder = remainder;

   div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .rem(rem_p),
      .next_bit(dvd_m[DATA_WIDTH-1]),
      .dvs(dvs_m),
      .rem_next(rem_n),
      .q_bit(q_bit)
   );

   // request acceptance, iteration sequencing and sign fixup; dvd_m shifts quotient bits in as dividend bits leave
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= DIV_IDLE;
         counter <= '0;
         rem_p <= '0;
         dvd_m <= '0;
         dvs_m <= '0;
         q_sign <= 1'b0;
         r_sign <= 1'b0;
         div_zero <= 1'b0;
         quotient <= '0;
         remainder <= '0;
      end else begin
         case (state)
            DIV_IDLE, DIV_DONE: begin
               state <= DIV_IDLE;
               if (bus.start) begin
                  div_zero <= bus.divisor == '0;
                  if (bus.divisor == '0) begin
                     state <= DIV_DONE;
                  end else begin
                     dvd_m <= dvd_neg ? -bus.dividend : bus.dividend;
                     dvs_m <= dvs_neg ? -bus.divisor : bus.divisor;
                     q_sign <= dvd_neg ^ dvs_neg;
                     r_sign <= dvd_neg;
                     rem_p <= '0;
                     counter <= '0;
                     state <= DIV_CALC;
                  end
               end
            end
            DIV_CALC: begin
               rem_p <= rem_n;
               dvd_m <= {dvd_m[DATA_WIDTH-2:0], q_bit};
               counter <= counter + CNT_WIDTH'(1);
               if (counter == CNT_WIDTH'(DIV_ITERS - 1)) state <= DIV_FIX;
            end
            DIV_FIX: begin
               quotient <= q_sign ? -dvd_m : dvd_m;
               remainder <= r_sign ? -rem_p : rem_p;
               state <= DIV_DONE;
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_responder.sv
// tb_div_responder: scoreboard bench for the signed multicycle divider
module tb_div_responder;
   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int cyc = 0;
   int checks = 0;
   int passed = 0;
   exp_t sb[$];
   exp_t mon_e;

   div_responder_if #(.DATA_WIDTH(32)) bus ();

   div_responder dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // edge counter: after edge En (counting from request edge) cyc = c0 + n
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   // monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL spurious_done: got done=1 at cycle %0d expected no pending request", cyc);
         end else begin
            mon_e = sb.pop_front();
            check("quotient", bus.quotient, mon_e.q);
            check("remainder", bus.remainder, mon_e.r);
            check("div_zero", {31'b0, bus.div_zero}, {31'b0, mon_e.dz});
            check("done_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez);
      @(negedge clk);
      bus.start = 1'b1;
      bus.dividend = a;
      bus.divisor = b;
      sb.push_back('{eq, er, ez, cyc + (ez ? 1 : 34)});
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
      check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      repeat (3) @(negedge clk);
      check("rst_quotient", bus.quotient, 32'd0);
      check("rst_remainder", bus.remainder, 32'd0);
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      check("rst_done", {31'b0, bus.done}, 32'd0);
      check("rst_div_zero", {31'b0, bus.div_zero}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      issue(32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
      check("busy_calc", {31'b0, bus.busy}, 32'd1);
      drain();
      check("busy_after_done", {31'b0, bus.busy}, 32'd0);

      issue(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
      drain();
      issue(32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
      drain();
      issue(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
      drain();
      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      drain();
      issue(32'd5, 32'd0, 32'd14, 32'd2, 1'b1);
      drain();
      repeat (3) @(negedge clk);
      check("div_zero_held", {31'b0, bus.div_zero}, 32'd1);
      issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
      check("div_zero_cleared", {31'b0, bus.div_zero}, 32'd0);
      drain();

      // reset during the 10th CALC cycle: no done, everything back to zero
      @(negedge clk);
      bus.start = 1'b1;
      bus.dividend = 32'd1000;
      bus.divisor = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
      check("mid_rst_done", {31'b0, bus.done}, 32'd0);
      check("mid_rst_quotient", bus.quotient, 32'd0);
      check("mid_rst_remainder", bus.remainder, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
      drain();

      // restart while busy is ignored, operand changes mid-CALC are ignored
      issue(32'd20, 32'd6, 32'd3, 32'd2, 1'b0);
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      bus.dividend = 32'd50;
      bus.divisor = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      bus.dividend = 32'd123;
      bus.divisor = 32'hFFFFFFF7;
      drain();
      repeat (5) @(negedge clk);
      check("final_queue_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
